// File: rtl/tx_packer.sv
// tx_packer: packs a 32-bit valid/ready/last word stream into 128-bit transactions,
// buffers them in a small FIFO and emits each one as a single-cycle o_valid pulse,
// with a programmable minimum idle gap between pulses. Malformed fragments are dropped
// and flagged with a one-cycle o_frag_err pulse.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   s_valid/s_ready/s_data/s_last  input word stream, word 0 is most significant
//   o_valid        one-cycle pulse per emitted transaction
//   o_transaction  last emitted transaction (held while o_valid=0)
//   o_frag_err     one-cycle pulse per dropped malformed fragment
//   o_tx_count     saturating count of emitted transactions
module tx_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_GAP    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         o_valid,
  output logic [127:0] o_transaction,
  output logic         o_frag_err,
  output logic [15:0]  o_tx_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [0:0] {StCollect, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [95:0]     shadow_q, shadow_d;
  logic            frag_err_q, frag_err_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            valid_q, valid_d;
  logic [127:0]    trans_q, trans_d;
  logic [15:0]     tx_cnt_q, tx_cnt_d;
  logic [127:0]    mem [FIFO_DEPTH];

  logic fifo_full, accept, push, pop;

  always_comb begin
    fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
    // Depends only on registered state (and reset); a same-cycle pop never frees a slot.
    s_ready    = !rst && ((state_q == StDiscard) || (k_q != 2'd3) || !fifo_full);
    accept     = s_valid && s_ready;

    push       = 1'b0;
    state_d    = state_q;
    k_d        = k_q;
    shadow_d   = shadow_q;
    frag_err_d = 1'b0;

    if (accept) begin
      unique case (state_q)
        StCollect: begin
          if (k_q != 2'd3) begin
            if (s_last) begin
              k_d        = 2'd0;
              frag_err_d = 1'b1;
            end else begin
              // Shift-in leaves word 0 in [95:64], i.e. the top of the final transaction.
              shadow_d = {shadow_q[63:0], s_data};
              k_d      = k_q + 2'd1;
            end
          end else begin
            k_d = 2'd0;
            if (s_last) begin
              push = 1'b1;
            end else begin
              frag_err_d = 1'b1;
              state_d    = StDiscard;
            end
          end
        end
        StDiscard: begin
          if (s_last) state_d = StCollect;
        end
        default: state_d = StCollect;
      endcase
    end

    pop = (cnt_q != '0) && (gap_q == '0);

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    if (!push && pop) cnt_d = cnt_q - CntW'(1);

    gap_d = gap_q;
    if (pop)                gap_d = GapW'(MIN_GAP);
    else if (gap_q != '0)   gap_d = gap_q - GapW'(1);

    valid_d  = pop;
    trans_d  = pop ? mem[rd_ptr_q] : trans_q;
    tx_cnt_d = (pop && (tx_cnt_q != 16'hFFFF)) ? tx_cnt_q + 16'd1 : tx_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCollect;
      k_q        <= 2'd0;
      shadow_q   <= '0;
      frag_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      trans_q    <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      shadow_q   <= shadow_d;
      frag_err_q <= frag_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      trans_q    <= trans_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {shadow_q, s_data};
  end

  assign o_valid       = valid_q;
  assign o_transaction = trans_q;
  assign o_frag_err    = frag_err_q;
  assign o_tx_count    = tx_cnt_q;

endmodule

// File: tb/tb_tx_packer.sv
module tb_tx_packer;
  localparam int unsigned Depth = 4;
  localparam int unsigned Gap   = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         o_valid, o_frag_err;
  logic [127:0] o_transaction;
  logic [15:0]  o_tx_count;

  tx_packer #(.FIFO_DEPTH(Depth), .MIN_GAP(Gap)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .o_valid       (o_valid),
    .o_transaction (o_transaction),
    .o_frag_err    (o_frag_err),
    .o_tx_count    (o_tx_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0][31:0] w;
    int               n;
    int               last_idx;
    bit               emit;
    bit               frag;
  } vec_t;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_q[$];
  int           n_valid = 0;
  int           n_frag = 0;
  int           last_valid_cyc = -1000;
  int           prev_cyc = -1000;
  logic [15:0]  model_cnt = 16'd0;
  bit           saw_stall = 0;
  bit           mon_en = 0;
  int           last_acc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4, input logic [31:0] w5,
                              input int n, input int last_idx, input bit emit, input bit frag);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.n = n; v.last_idx = last_idx; v.emit = emit; v.frag = frag;
    return v;
  endfunction

  // Output monitor: scoreboard pop, count model, gap spacing.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_frag_err) n_frag++;
        if (o_valid) begin
          n_valid++;
          if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
          check("tx_count", 128'(o_tx_count), 128'(model_cnt));
          if (exp_q.size() == 0) begin
            check("unexpected_tx", o_transaction, 128'(0) - 128'(1));
          end else begin
            e = exp_q.pop_front();
            check("tx_data", o_transaction, e);
          end
          if (prev_cyc > -1000) check("pulse_gap", 128'((cyc - prev_cyc) >= int'(Gap + 1)), 128'(1));
          prev_cyc       = cyc;
          last_valid_cyc = cyc;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, output int acc_cyc);
    bit done;
    bit r;
    int tries;
    done  = 0;
    tries = 0;
    acc_cyc = -1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!done) begin
      #1;
      r = s_ready;
      if (!r) saw_stall = 1;
      acc_cyc = cyc;
      @(posedge clk);
      if (r) begin
        done = 1;
      end else begin
        tries++;
        if (tries > 200) begin
          n_checks++;
          n_errors++;
          $display("FAIL accept_timeout: s_ready stayed 0, required 1 within 200 cycles");
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic send_vec(input vec_t v);
    int a;
    for (int i = 0; i < v.n; i++) begin
      send_word(v.w[i], (i == v.last_idx), a);
      if (i == v.last_idx && v.emit) begin
        exp_q.push_back({v.w[0], v.w[1], v.w[2], v.w[3]});
        last_acc = a;
      end
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (exp_q.size() != 0 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d transactions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    int fv, ff;
    int a;
    vec_t v;

    tbl[0] = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 4, 3, 1, 0);
    tbl[1] = mk(32'hA0A0A0A0, 32'hA1A1A1A1, 0, 0, 0, 0, 2, 1, 0, 1);
    tbl[2] = mk(32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF, 0, 0, 4, 3, 1, 0);
    tbl[3] = mk(32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3,
                32'hB4B4B4B4, 32'hB5B5B5B5, 6, 5, 0, 1);
    tbl[4] = mk(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 0, 0, 4, 3, 1, 0);
    tbl[5] = mk(32'hC0C0C0C0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[6] = mk(32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3,
                32'hD4D4D4D4, 0, 5, 4, 0, 1);
    tbl[7] = mk(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 0, 4, 3, 1, 0);

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_o_valid", 128'(o_valid), 128'(0));
    check("rst_o_frag_err", 128'(o_frag_err), 128'(0));
    check("rst_o_transaction", o_transaction, 128'(0));
    check("rst_o_tx_count", 128'(o_tx_count), 128'(0));
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // Table-driven single transactions and fragments.
    for (int i = 0; i < 8; i++) begin
      fv = n_valid;
      ff = n_frag;
      send_vec(tbl[i]);
      wait_idle();
      check($sformatf("vec%0d_emitted", i), 128'(n_valid - fv), 128'(tbl[i].emit));
      check($sformatf("vec%0d_frag", i), 128'(n_frag - ff), 128'(tbl[i].frag));
      if (tbl[i].emit) check($sformatf("vec%0d_latency", i), 128'(last_valid_cyc),
                             128'(last_acc + 2));
    end

    // Full-rate stream deep enough to fill the FIFO under the idle gap.
    fv = n_valid;
    saw_stall = 0;
    for (int t = 0; t < 10; t++) begin
      v = mk(32'hA5000000 | 32'(t * 16 + 0), 32'hA5000000 | 32'(t * 16 + 1),
             32'hA5000000 | 32'(t * 16 + 2), 32'hA5000000 | 32'(t * 16 + 3), 0, 0, 4, 3, 1, 0);
      send_vec(v);
    end
    wait_idle();
    check("stream_emitted", 128'(n_valid - fv), 128'(10));
    check("stream_stalled", 128'(saw_stall), 128'(1));

    // Reset after two words of a transaction discards them.
    send_word(32'hEEEE0000, 1'b0, a);
    send_word(32'hEEEE0001, 1'b0, a);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_s_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    check("midrst_o_valid", 128'(o_valid), 128'(0));
    check("midrst_o_frag_err", 128'(o_frag_err), 128'(0));
    check("midrst_o_transaction", o_transaction, 128'(0));
    check("midrst_o_tx_count", 128'(o_tx_count), 128'(0));
    model_cnt = 16'd0;
    prev_cyc  = -1000;
    fv = n_valid;
    ff = n_frag;
    send_vec(tbl[2]);
    wait_idle();
    check("postrst_emitted", 128'(n_valid - fv), 128'(1));
    check("postrst_frag", 128'(n_frag - ff), 128'(0));

    // Counter saturation.
    @(negedge clk);
    force u_dut.tx_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u_dut.tx_cnt_q;
    model_cnt = 16'hFFFE;
    @(negedge clk);
    check("sat_preload", 128'(o_tx_count), 128'(16'hFFFE));
    send_vec(tbl[0]);
    send_vec(tbl[4]);
    send_vec(tbl[7]);
    wait_idle();
    check("sat_final", 128'(o_tx_count), 128'(16'hFFFF));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
